log2_iter: RTL and testbench
============================

LOG2_ITER -- requirements
Module: log2_iter

Interface
REQ-001 SHALL have parameter: width_p, 32, operand width in bits.
REQ-002 SHALL have parameter: lg_width_lp, $clog2(width_p), result width (localparam, not overridable).
REQ-003 SHALL have port: clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: data_i  input  width_p  operand x.
REQ-006 SHALL have port: v_i  input  1  operand valid.
REQ-007 SHALL have port: ready_o  output  1  block can accept an operand.
REQ-008 SHALL have port: log_o  output  lg_width_lp  floor(log2(x)).
REQ-009 SHALL have port: exact_o  output  1  x was an exact power of two.
REQ-010 SHALL have port: zero_o  output  1  x was zero (log_o invalid, driven 0).
REQ-011 SHALL have port: v_o  output  1  result valid.
REQ-012 SHALL have port: yumi_i  input  1  consumer takes result this cycle; legal only while v_o=1.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 SHALL assert ready_o only in IDLE; v_o only in DONE; outputs are registered, with no combinational path from any input to any output.
REQ-015 SHALL accept an operand on a rising edge with v_i=1 and ready_o=1; v_i in BUSY/DONE is ignored and data_i is not sampled.
REQ-016 On accept with x!=0: load shift register with x, count=0, sticky=0, go BUSY.
REQ-017 On accept with x==0: set zero_o=1, log_o=0, exact_o=0, go straight to DONE; v_o is high in the next cycle.
REQ-018 Each BUSY cycle: if shift[width_p-1:1]==0, go DONE with log_o=count and exact_o=~sticky; else shift right 1, count+1, sticky|=shifted-out bit 0.
REQ-019 Latency: BUSY occupies floor(log2 x)+1 cycles; v_o rises on the edge that leaves BUSY.
REQ-020 DONE SHALL hold log_o/exact_o/zero_o/v_o stable until yumi_i=1; on that edge the FSM goes to IDLE and ready_o=1 in the following cycle. There is no accept in the same cycle as yumi_i.
REQ-021 yumi_i outside DONE SHALL be ignored with no state change.
REQ-022 The count SHALL never exceed width_p-1; the count register has lg_width_lp bits and SHALL NOT wrap.
REQ-023 Result fields SHALL keep their last values outside DONE; only v_o qualifies them.

Reset
REQ-024 reset_n_i=0 SHALL immediately force: state IDLE, v_o=0, log_o=0, exact_o=0, zero_o=0, count=0, shift=0, sticky=0.
REQ-025 Reset asserted in BUSY or DONE SHALL discard the operation; no v_o pulse follows.
REQ-026 After reset deassertion, ready_o=1 in the first cycle; deassertion is assumed synchronous to clk_i at the system level.

Structure
REQ-027 Shared package log2_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the default width constant.
REQ-028 SHALL be a single module with no sub-module; the datapath is shift register, counter and sticky bit.
REQ-029 SHALL be plug-compatible with the pow2 bench style: trace-replay driving v_i/ready_o, consuming v_o with yumi_i.

Verification
REQ-030 x=32'h1 -> 1 BUSY cycle; log_o=0, exact_o=1, zero_o=0.
REQ-031 x=32'h8000_0000 -> 32 BUSY cycles; log_o=31, exact_o=1.
REQ-032 x=32'h0000_0006 -> 3 BUSY cycles; log_o=2, exact_o=0; x=32'hFFFF_FFFF -> log_o=31, exact_o=0.
REQ-033 x=0 -> v_o high one cycle after accept; zero_o=1, log_o=0, exact_o=0.
REQ-034 Back-pressure: yumi_i held 0 for 10 cycles in DONE -> outputs unchanged, ready_o=0, v_i pulses ignored; yumi_i=1 -> IDLE, next operand accepted.
REQ-035 Reset asserted mid-BUSY (x=32'h0001_0000, cycle 5) -> all outputs 0 immediately, no v_o; next operand 32'h4 -> log_o=2, exact_o=1.

Source files
------------

// File: rtl/log2_pkg.sv
// Shared definitions for the iterative floor-log2 block: FSM states and default operand width.
package log2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } log2_state_e;

  localparam int LOG2_WIDTH_DEFAULT = 32;

endpackage

// File: rtl/log2_iter.sv
// Iterative floor(log2(x)): shifts the operand right one bit per cycle until only bit 0 may
// remain set, counting shifts; a sticky OR of shifted-out bits tells whether x was a power of two.
module log2_iter
  import log2_pkg::*;
#(
  parameter  int width_p     = LOG2_WIDTH_DEFAULT,
  localparam int lg_width_lp = $clog2(width_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic [width_p-1:0]     data_i,
  input  logic                   v_i,
  output logic                   ready_o,
  output logic [lg_width_lp-1:0] log_o,
  output logic                   exact_o,
  output logic                   zero_o,
  output logic                   v_o,
  input  logic                   yumi_i
);

  log2_state_e state_r, state_n;

  logic [width_p-1:0]     shift_r;
  logic [lg_width_lp-1:0] count_r;
  logic                   sticky_r;
  logic                   last_w;

  // Nothing above bit 0 left: count already equals the index of the leading one.
  assign last_w = (shift_r[width_p-1:1] == '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (v_i) state_n = (data_i == '0) ? DONE : BUSY;
      BUSY:    if (last_w) state_n = DONE;
      DONE:    if (yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_r == IDLE);
    v_o     = (state_r == DONE);
  end

  // Result fields are only written when entering DONE, so they hold outside it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      shift_r  <= '0;
      count_r  <= '0;
      sticky_r <= 1'b0;
      log_o    <= '0;
      exact_o  <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (v_i) begin
            if (data_i == '0) begin
              zero_o  <= 1'b1;
              log_o   <= '0;
              exact_o <= 1'b0;
            end else begin
              shift_r  <= data_i;
              count_r  <= '0;
              sticky_r <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (last_w) begin
            log_o   <= count_r;
            exact_o <= ~sticky_r;
            zero_o  <= 1'b0;
          end else begin
            shift_r  <= shift_r >> 1;
            count_r  <= count_r + 1'b1;
            sticky_r <= sticky_r | shift_r[0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_log2_iter.sv
// Randomized scoreboard bench for log2_iter: driver pushes expected results, monitor pops on v_o.
module tb_log2_iter;

  localparam int W  = 32;
  localparam int LW = $clog2(W);

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [W-1:0]  data_i;
  logic          v_i;
  logic          ready_o;
  logic [LW-1:0] log_o;
  logic          exact_o;
  logic          zero_o;
  logic          v_o;
  logic          yumi_i;

  log2_iter #(.width_p(W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .data_i(data_i), .v_i(v_i),
    .ready_o(ready_o), .log_o(log_o), .exact_o(exact_o), .zero_o(zero_o),
    .v_o(v_o), .yumi_i(yumi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] x;
    int           lg;
    bit           exact;
    bit           zero;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_done = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: floor(log2 x) as the largest i with 2^i <= x; exact when x has one set bit.
  function automatic exp_t model(input logic [W-1:0] x);
    exp_t e;
    e.x = x; e.lg = 0; e.zero = (x == 0); e.exact = 0;
    for (int i = 0; i < W; i++)
      if (64'(x) >= (64'd1 << i)) e.lg = i;
    if (x != 0) e.exact = ((x & (x - 1)) == 0);
    e.lat = e.zero ? 0 : e.lg + 1;
    return e;
  endfunction

  // Monitor: compare on first v_o cycle, then check stability while yumi is withheld.
  initial begin
    exp_t cur;
    bit   seen = 0;
    int   hold = 0;
    yumi_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!reset_n_i) begin
        seen = 0; yumi_i = 1'b0;
      end else if (v_o) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_v_o", 1, 0);
            cur.lg = int'(log_o); cur.exact = exact_o; cur.zero = zero_o;
            hold = 0;
          end else begin
            cur = exp_q.pop_front();
            chk($sformatf("log x=%h", cur.x), log_o, cur.lg);
            chk($sformatf("exact x=%h", cur.x), exact_o, cur.exact);
            chk($sformatf("zero x=%h", cur.x), zero_o, cur.zero);
            chk($sformatf("latency x=%h", cur.x), cyc - cur.acc, cur.lat);
            hold = (n_done % 7 == 2) ? 10 : int'($urandom_range(0, 3));
            n_done++;
          end
          seen = 1;
        end else begin
          chk("hold_log", log_o, cur.lg);
          chk("hold_exact", exact_o, cur.exact);
          chk("hold_zero", zero_o, cur.zero);
          chk("hold_ready", ready_o, 0);
        end
        if (hold == 0) begin yumi_i = 1'b1; seen = 0; end
        else begin hold--; yumi_i = 1'b0; end
      end else begin
        yumi_i = 1'b0;
      end
    end
  end

  // Wait for ready_o while throwing ignored v_i noise, then present x for one accept edge.
  task automatic send(input logic [W-1:0] x);
    exp_t e;
    int   n = 0;
    forever begin
      @(negedge clk_i);
      if (ready_o) break;
      v_i = $urandom_range(0, 1); data_i = $urandom;
      if (++n > 500) begin chk("ready_timeout", 0, 1); v_i = 1'b0; return; end
    end
    v_i = 1'b1; data_i = x;
    e = model(x);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk_i);
    v_i = 1'b0; data_i = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 || v_o) begin
      @(negedge clk_i);
      if (++n > 2000) begin chk("drain_timeout", exp_q.size(), 0); exp_q.delete(); return; end
    end
  endtask

  logic [W-1:0] dir_tbl [6];
  initial begin
    int vcount;
    logic [W-1:0] x;
    dir_tbl[0] = 32'h1;
    dir_tbl[1] = 32'h8000_0000;
    dir_tbl[2] = 32'h6;
    dir_tbl[3] = 32'hFFFF_FFFF;
    dir_tbl[4] = 32'h0;
    dir_tbl[5] = 32'h4;
    reset_n_i = 1'b0; v_i = 1'b0; data_i = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_v_o", v_o, 0);
    chk("rst_log", log_o, 0);
    chk("rst_exact", exact_o, 0);
    chk("rst_zero", zero_o, 0);
    reset_n_i = 1'b1;
    #1 chk("ready_after_rst", ready_o, 1);

    foreach (dir_tbl[i]) send(dir_tbl[i]);
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       x = '0;
        1:       x = 32'h1 << $urandom_range(0, W - 1);
        default: x = $urandom >> $urandom_range(0, W - 1);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      send(x);
    end
    drain();

    // Reset in the middle of a long operation discards it.
    send(32'h0001_0000);
    repeat (4) @(negedge clk_i);
    reset_n_i = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_v_o", v_o, 0);
    chk("midrst_log", log_o, 0);
    chk("midrst_exact", exact_o, 0);
    chk("midrst_zero", zero_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    #1 chk("midrst_ready", ready_o, 1);
    vcount = 0;
    repeat (20) begin @(negedge clk_i); if (v_o) vcount++; end
    chk("midrst_no_v_o", vcount, 0);
    send(32'h4);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
